// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// the width and saturation limit of the lock-loss statistics counter.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_HOLDOFF   = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_e;

  localparam int                LOSS_W   = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = 8'd255;
  localparam logic [LOSS_W-1:0] LOSS_ONE = 8'd1;

  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] value);
    return (value == LOSS_MAX) ? value : value + LOSS_ONE;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL side (master) and the reset sequencer (slave).
interface pll_reset_sequencer_if
  import pll_reset_sequencer_pkg::*;
();

  logic              locked;
  logic              clear_stats;
  logic              sys_resetn;
  logic              ready;
  logic              lock_lost;
  logic [LOSS_W-1:0] loss_count;

  modport master (
    output locked,
    output clear_stats,
    input  sys_resetn,
    input  ready,
    input  lock_lost,
    input  loss_count
  );

  modport slave (
    input  locked,
    input  clear_stats,
    output sys_resetn,
    output ready,
    output lock_lost,
    output loss_count
  );

endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, with async active-low clear.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds downstream logic in reset until the PLL lock has been stable long enough,
// and keeps sticky statistics on locks lost while running.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 16,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 resetn,
  pll_reset_sequencer_if.slave bus
);

  localparam int CNT_SPAN = (LOCK_FILTER > HOLDOFF_CYCLES) ? LOCK_FILTER : HOLDOFF_CYCLES;
  localparam int CNT_W    = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;

  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              lock_lost_q;
  logic              lock_lost_d;
  logic [LOSS_W-1:0] loss_count_q;
  logic [LOSS_W-1:0] loss_count_d;
  logic              locked_s;
  logic              run_loss;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clock),
    .rst_ni (resetn),
    .d_i    (bus.locked),
    .q_o    (locked_s)
  );

  assign run_loss = (state_q == ST_RUN) && !locked_s;

  // A loss in the same cycle as a clear wins, leaving exactly one recorded loss.
  always_comb begin
    lock_lost_d  = lock_lost_q;
    loss_count_d = loss_count_q;
    if (run_loss) begin
      lock_lost_d  = 1'b1;
      loss_count_d = bus.clear_stats ? LOSS_ONE : sat_inc(loss_count_q);
    end else if (bus.clear_stats) begin
      lock_lost_d  = 1'b0;
      loss_count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      lock_lost_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      lock_lost_q  <= lock_lost_d;
      loss_count_q <= loss_count_d;
      case (state_q)
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= ST_FILTER;
            cnt_q   <= '0;
          end
        end
        ST_FILTER: begin
          if (!locked_s) begin
            state_q <= ST_WAIT_LOCK;
          end else if (cnt_q == FILTER_LAST) begin
            state_q <= ST_HOLDOFF;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HOLDOFF: begin
          if (!locked_s) begin
            state_q <= ST_LOST;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_q <= ST_LOST;
          end
        end
        ST_LOST: begin
          state_q <= ST_WAIT_LOCK;
        end
        default: begin
          state_q <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

  // Outputs come straight off the state register so no input can glitch them.
  assign bus.sys_resetn = (state_q == ST_RUN);
  assign bus.ready      = (state_q == ST_RUN);
  assign bus.lock_lost  = lock_lost_q;
  assign bus.loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a streak-counting reference model checked every
// cycle, plus directed scenarios pinned to hand-derived edge numbers.
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;

  localparam int SYNC   = 2;
  localparam int LF     = 4;
  localparam int HC     = 8;
  localparam int ACCEPT = 1 + LF + HC;

  logic clock  = 1'b0;
  logic resetn = 1'b1;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .LOCK_FILTER    (LF),
    .HOLDOFF_CYCLES (HC)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: lock is accepted once the synchronised input has been high for
  // ACCEPT consecutive counted edges; dropping after the filter has passed costs
  // one dead edge before counting restarts.
  int  edgeCnt    = 0;
  bit  hist[SYNC];
  int  streak     = 0;
  int  dead       = 0;
  bit  expLost    = 1'b0;
  int  expCount   = 0;
  bit  modelOk;
  bit  modelRunLoss;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      edgeCnt  = 0;
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      streak   = 0;
      dead     = 0;
      expLost  = 1'b0;
      expCount = 0;
    end else begin
      edgeCnt++;
      modelOk = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.locked;
      modelRunLoss = 1'b0;
      if (dead > 0) begin
        dead--;
        streak = 0;
      end else if (modelOk) begin
        if (streak < ACCEPT) streak++;
      end else begin
        if (streak >= ACCEPT) modelRunLoss = 1'b1;
        if (streak >= LF + 1) dead = 1;
        streak = 0;
      end
      if (modelRunLoss) begin
        expLost  = 1'b1;
        expCount = bus.clear_stats ? 1 : ((expCount < 255) ? expCount + 1 : 255);
      end else if (bus.clear_stats) begin
        expLost  = 1'b0;
        expCount = 0;
      end
    end
  end

  logic        prevReady = 1'b0;
  int          riseEdge  = -1;
  int          fallEdge  = -1;
  logic [10:0] actVec;
  logic [10:0] expVec;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycleCheck();
    actVec = {bus.sys_resetn, bus.ready, bus.lock_lost, bus.loss_count};
    expVec = {streak == ACCEPT, streak == ACCEPT, expLost, 8'(expCount)};
    testsRun++;
    if (actVec !== expVec) begin
      testsFailed++;
      $display("[TB] FAIL cycleCheck edge %0d: got sysr=%b rdy=%b lost=%b cnt=%0d, expected sysr=%b rdy=%b lost=%b cnt=%0d",
               edgeCnt, actVec[10], actVec[9], actVec[8], actVec[7:0],
               expVec[10], expVec[9], expVec[8], expVec[7:0]);
    end
    if (bus.ready && !prevReady && riseEdge < 0) riseEdge = edgeCnt;
    if (!bus.ready && prevReady && fallEdge < 0) fallEdge = edgeCnt;
    prevReady = bus.ready;
  endtask

  task automatic stepNeg();
    @(negedge clock);
    #1;
  endtask

  task automatic waitEdge(input int target);
    while (edgeCnt < target) stepNeg();
  endtask

  task automatic waitReady(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (bus.ready !== val && n < budget) begin
      stepNeg();
      n++;
    end
    checkOutput(name, bus.ready, val);
  endtask

  // Drops locked for one cycle; the optional clear lands on the RUN->LOST edge.
  task automatic dropLock(input logic withClear);
    bus.locked = 1'b0;
    stepNeg();
    bus.locked = 1'b1;
    stepNeg();
    bus.clear_stats = withClear;
    stepNeg();
    bus.clear_stats = 1'b0;
  endtask

  task automatic resetPulse();
    resetn = 1'b0;
    stepNeg();
    stepNeg();
    resetn = 1'b1;
  endtask

  task automatic applyStimulus(input logic lockVal, input int cycles);
    bus.locked = lockVal;
    repeat (cycles) begin
      bus.clear_stats = ($urandom_range(0, 15) == 0);
      stepNeg();
    end
    bus.clear_stats = 1'b0;
  endtask

  task automatic runScenarios();
    int k;
    bus.locked      = 1'b0;
    bus.clear_stats = 1'b0;
    #1 resetn = 1'b0;
    stepNeg();
    stepNeg();
    checkOutput("resetSysResetn", bus.sys_resetn, 0);
    checkOutput("resetReady", bus.ready, 0);
    checkOutput("resetLockLost", bus.lock_lost, 0);
    checkOutput("resetLossCount", bus.loss_count, 0);

    // Clean lock rising after edge 10.
    resetn   = 1'b1;
    riseEdge = -1;
    waitEdge(10);
    bus.locked = 1'b1;
    waitReady(1'b1, 40, "s1Ready");
    checkOutput("s1RiseEdge", riseEdge, 25);

    // Three-cycle glitch, then a stable rise after edge 12.
    bus.locked = 1'b0;
    resetPulse();
    riseEdge = -1;
    waitEdge(5);
    bus.locked = 1'b1;
    waitEdge(8);
    bus.locked = 1'b0;
    waitEdge(12);
    bus.locked = 1'b1;
    waitReady(1'b1, 40, "s2Ready");
    checkOutput("s2RiseEdge", riseEdge, 27);

    // One-cycle loss while running.
    k = edgeCnt;
    fallEdge = -1;
    riseEdge = -1;
    dropLock(1'b0);
    waitReady(1'b0, 10, "s3Fall");
    checkOutput("s3FallEdge", fallEdge, k + 3);
    checkOutput("s3LockLost", bus.lock_lost, 1);
    checkOutput("s3LossCount", bus.loss_count, 1);
    waitReady(1'b1, 40, "s3Relock");
    checkOutput("s3RiseEdge", riseEdge, k + 17);

    // Saturation, then a clear coincident with a loss, then a lone clear.
    for (int i = 0; i < 259; i++) begin
      dropLock(1'b0);
      waitReady(1'b1, 40, "s4Relock");
    end
    checkOutput("s4Saturated", bus.loss_count, 255);
    checkOutput("s4LockLost", bus.lock_lost, 1);
    dropLock(1'b1);
    checkOutput("s4ClearLossCount", bus.loss_count, 1);
    checkOutput("s4ClearLockLost", bus.lock_lost, 1);
    waitReady(1'b1, 40, "s4FinalRelock");
    bus.clear_stats = 1'b1;
    stepNeg();
    bus.clear_stats = 1'b0;
    checkOutput("s4LoneClearCount", bus.loss_count, 0);
    checkOutput("s4LoneClearLost", bus.lock_lost, 0);

    // Reset asserted at HOLDOFF count 5 during a relock.
    k = edgeCnt;
    dropLock(1'b0);
    waitEdge(k + 13);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    checkOutput("s5SysResetn", bus.sys_resetn, 0);
    checkOutput("s5Ready", bus.ready, 0);
    checkOutput("s5LockLost", bus.lock_lost, 0);
    checkOutput("s5LossCount", bus.loss_count, 0);
    stepNeg();
    stepNeg();
    resetn   = 1'b1;
    riseEdge = -1;
    waitReady(1'b1, 40, "s5Ready");
    checkOutput("s5RiseEdge", riseEdge, 15);

    // Loss during HOLDOFF detours through LOST and leaves the statistics alone.
    k = edgeCnt;
    dropLock(1'b0);
    riseEdge = -1;
    waitEdge(k + 9);
    bus.locked = 1'b0;
    stepNeg();
    bus.locked = 1'b1;
    waitReady(1'b1, 40, "s6Ready");
    checkOutput("s6RiseEdge", riseEdge, k + 26);
    checkOutput("s6LossCount", bus.loss_count, 1);
    checkOutput("s6LockLost", bus.lock_lost, 1);

    // Randomised lock segments, clear pulses and occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 29) == 0) begin
        resetn = 1'b0;
        stepNeg();
        resetn = 1'b1;
      end
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(1, 30));
    end
    stepNeg();
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clock);
          cycleCheck();
        end
      end
      begin
        runScenarios();
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
